// File: rtl/key_conditioner_pkg.sv
// Shared FSM state encodings, default timing constants and counter sizing for the key conditioner.
package key_conditioner_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DEB_P = 3'd1;
    localparam logic [2:0] ST_HOLD  = 3'd2;
    localparam logic [2:0] ST_RPT   = 3'd3;
    localparam logic [2:0] ST_DEB_R = 3'd4;

    localparam int unsigned DEF_DEBOUNCE_CYC = 500000;
    localparam int unsigned DEF_REPEAT_DELAY = 25000000;
    localparam int unsigned DEF_REPEAT_RATE  = 5000000;

    // Counter width covering the longest interval any state has to time.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return 32'($clog2(m));
    endfunction

endpackage

// File: rtl/key_channel.sv
// One key: two-flop synchroniser, debounce/auto-repeat FSM and registered press/step/held outputs.
module key_channel
    import key_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic press,
    output logic step,
    output logic held
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYC, REPEAT_DELAY, REPEAT_RATE);
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    logic [1:0]       sync;
    logic             s;
    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             cnt_clr;
    logic             press_nxt;
    logic             step_nxt;
    logic             held_nxt;

    assign s = sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b11;
            state <= ST_IDLE;
            cnt   <= '0;
            press <= 1'b0;
            step  <= 1'b0;
            held  <= 1'b0;
        end else begin
            sync  <= {sync[0], key};
            state <= state_nxt;
            cnt   <= cnt_nxt;
            press <= press_nxt;
            step  <= step_nxt;
            held  <= held_nxt;
        end
    end

    // A level change on s always takes priority over a timer expiry, so release beats repeat.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        press_nxt = 1'b0;
        step_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!s) state_nxt = ST_DEB_P;
            end
            ST_DEB_P: begin
                if (s) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = ST_HOLD;
                    press_nxt = 1'b1;
                    step_nxt  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (s) begin
                    state_nxt = ST_DEB_R;
                end else if (cnt == DELAY_LAST) begin
                    state_nxt = ST_RPT;
                    step_nxt  = 1'b1;
                end
            end
            ST_RPT: begin
                if (s) begin
                    state_nxt = ST_DEB_R;
                end else if (cnt == RATE_LAST) begin
                    step_nxt = 1'b1;
                    cnt_clr  = 1'b1;
                end
            end
            ST_DEB_R: begin
                if (!s) begin
                    state_nxt = ST_HOLD;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // IDLE parks the counter at zero so it never free-runs.
        if ((state_nxt != state) || cnt_clr || (state == ST_IDLE)) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt + CNT_W'(1);
        end

        held_nxt = state_nxt inside {ST_HOLD, ST_RPT, ST_DEB_R};
    end

endmodule

// File: rtl/key_conditioner.sv
// Three independent key channels turning raw DE2 push-buttons into press/step/held signals.
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic KEY3,
    input  logic KEY2,
    input  logic KEY1,
    output logic PRESS3,
    output logic PRESS2,
    output logic PRESS1,
    output logic STEP3,
    output logic STEP2,
    output logic STEP1,
    output logic HELD3,
    output logic HELD2,
    output logic HELD1
);

    key_channel #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_ch1 (
        .clk  (CLK),
        .rst_n(RSTN),
        .key  (KEY1),
        .press(PRESS1),
        .step (STEP1),
        .held (HELD1)
    );

    key_channel #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_ch2 (
        .clk  (CLK),
        .rst_n(RSTN),
        .key  (KEY2),
        .press(PRESS2),
        .step (STEP2),
        .held (HELD2)
    );

    key_channel #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_ch3 (
        .clk  (CLK),
        .rst_n(RSTN),
        .key  (KEY3),
        .press(PRESS3),
        .step (STEP3),
        .held (HELD3)
    );

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed test-plan scenarios plus random key activity against a run-length reference model.
module tb_key_conditioner;

    localparam int unsigned DEB = 4;
    localparam int unsigned RD  = 10;
    localparam int unsigned RR  = 3;

    logic clk = 1'b0;
    logic rstn;
    logic key1, key2, key3;
    logic press1, press2, press3, step1, step2, step3, held1, held2, held3;

    int checks   = 0;
    int failures = 0;

    logic [8:0] exp_q[$];

    int cnt_press[3];
    int cnt_step[3];
    int cnt_fall[3];
    time last_press_t[3];
    int base_p[3];
    int base_s[3];
    int base_f[3];

    // Reference model state: synchroniser stages and run lengths of the synchronised level.
    logic sh1[3];
    logic sh2[3];
    bit   m_held[3];
    int   zrun[3];
    int   orun[3];
    bit   inz[3];
    int   z[3];

    key_conditioner #(
        .DEBOUNCE_CYC(DEB),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE (RR)
    ) dut (
        .CLK   (clk),
        .RSTN  (rstn),
        .KEY3  (key3),
        .KEY2  (key2),
        .KEY1  (key1),
        .PRESS3(press3),
        .PRESS2(press2),
        .PRESS1(press1),
        .STEP3 (step3),
        .STEP2 (step2),
        .STEP1 (step1),
        .HELD3 (held3),
        .HELD2 (held2),
        .HELD1 (held1)
    );

    always #5 clk = ~clk;

    // Model: press after DEB+1 consecutive low samples, release after DEB+1 high samples,
    // steps at RD and then every RR cycles into an unbroken low run that began the hold.
    always @(posedge clk) begin
        logic [2:0] pins;
        logic [8:0] e;
        bit s, p, st;
        pins = {key3, key2, key1};
        if (!rstn) begin
            for (int c = 0; c < 3; c++) begin
                sh1[c] = 1'b1; sh2[c] = 1'b1; m_held[c] = 0;
                zrun[c] = 0; orun[c] = 0; inz[c] = 0; z[c] = 0;
            end
        end else begin
            e = '0;
            for (int c = 0; c < 3; c++) begin
                s = sh2[c];
                sh2[c] = sh1[c];
                sh1[c] = pins[c];
                p = 0;
                st = 0;
                if (!m_held[c]) begin
                    zrun[c] = s ? 0 : zrun[c] + 1;
                    if (zrun[c] == int'(DEB) + 1) begin
                        m_held[c] = 1; p = 1; st = 1;
                        z[c] = 0; inz[c] = 1; orun[c] = 0;
                    end
                end else if (s) begin
                    inz[c] = 0;
                    orun[c]++;
                    if (orun[c] == int'(DEB) + 1) begin
                        m_held[c] = 0; zrun[c] = 0;
                    end
                end else begin
                    orun[c] = 0;
                    if (!inz[c]) begin
                        inz[c] = 1; z[c] = 0;
                    end else begin
                        z[c]++;
                        if (z[c] >= int'(RD) && ((z[c] - int'(RD)) % int'(RR)) == 0) st = 1;
                    end
                end
                e[c*3 +: 3] = {p, st, m_held[c]};
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: every cycle the DUT presents a full output vector; compare it with the scoreboard.
    always @(negedge clk) begin
        logic [8:0] got;
        logic [8:0] exp;
        got = {press3, step3, held3, press2, step2, held2, press1, step1, held1};
        if (!rstn) begin
            exp_q.delete();
            checks++;
            if (got != 9'd0) begin
                failures++;
                $display("FAIL reset_outputs t=%0t got=%b exp=%b", $time, got, 9'd0);
            end
        end else begin
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 9'd0;
            checks++;
            if (got != exp) begin
                failures++;
                $display("FAIL out_vec t=%0t got=%b exp=%b", $time, got, exp);
            end
        end
        for (int c = 0; c < 3; c++) begin
            if (got[c*3+2]) begin
                cnt_press[c]++;
                last_press_t[c] = $time;
            end
            if (got[c*3+1]) cnt_step[c]++;
        end
    end

    always @(negedge held1) cnt_fall[0]++;
    always @(negedge held2) cnt_fall[1]++;
    always @(negedge held3) cnt_fall[2]++;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic snap();
        for (int c = 0; c < 3; c++) begin
            base_p[c] = cnt_press[c];
            base_s[c] = cnt_step[c];
            base_f[c] = cnt_fall[c];
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, act, req);
        end
    endtask

    initial begin
        int dur[3];
        logic [2:0] lvl;
        time rise_t;

        for (int c = 0; c < 3; c++) begin
            cnt_press[c] = 0; cnt_step[c] = 0; cnt_fall[c] = 0; last_press_t[c] = 0;
        end
        rstn = 1'b0;
        key1 = 1'b1; key2 = 1'b1; key3 = 1'b1;
        cyc(3);
        rstn = 1'b1;
        cyc(3);

        // Clean press and release on KEY1.
        snap();
        key1 = 1'b0; cyc(12);
        key1 = 1'b1; cyc(15);
        chk("s1_press1", cnt_press[0] - base_p[0], 1);
        chk("s1_step1", cnt_step[0] - base_s[0], 1);
        chk("s1_fall1", cnt_fall[0] - base_f[0], 1);
        chk("s1_step23", (cnt_step[1] - base_s[1]) + (cnt_step[2] - base_s[2]), 0);

        // Bounce rejection on KEY2.
        snap();
        key2 = 1'b0; cyc(3);
        key2 = 1'b1; cyc(1);
        key2 = 1'b0; cyc(2);
        key2 = 1'b1; cyc(10);
        chk("s2_press2", cnt_press[1] - base_p[1], 0);
        chk("s2_step2", cnt_step[1] - base_s[1], 0);

        // Auto-repeat on KEY3: press step plus five repeats.
        snap();
        key3 = 1'b0; cyc(28);
        key3 = 1'b1; cyc(15);
        chk("s3_press3", cnt_press[2] - base_p[2], 1);
        chk("s3_step3", cnt_step[2] - base_s[2], 6);

        // Release glitch on KEY1: hold survives, repeat delay restarts.
        snap();
        key1 = 1'b0; cyc(12);
        key1 = 1'b1; cyc(2);
        key1 = 1'b0; cyc(20);
        key1 = 1'b1; cyc(15);
        chk("s4_press1", cnt_press[0] - base_p[0], 1);
        chk("s4_fall1", cnt_fall[0] - base_f[0], 1);
        chk("s4_step1", cnt_step[0] - base_s[0], 5);

        // Simultaneous KEY1 and KEY3.
        snap();
        key1 = 1'b0; key3 = 1'b0; cyc(10);
        key1 = 1'b1; key3 = 1'b1; cyc(15);
        chk("s5_press1", cnt_press[0] - base_p[0], 1);
        chk("s5_press3", cnt_press[2] - base_p[2], 1);
        chk("s5_same_cycle", int'(last_press_t[0] == last_press_t[2]), 1);
        chk("s5_key2", (cnt_press[1] - base_p[1]) + (cnt_step[1] - base_s[1]), 0);

        // Reset during RPT with KEY3 held: one fresh press DEB+3 edges after release of reset.
        snap();
        key3 = 1'b0; cyc(20);
        rstn = 1'b0; cyc(3);
        rstn = 1'b1;
        rise_t = $time;
        chk("s6_press_before", cnt_press[2] - base_p[2], 1);
        snap();
        cyc(15);
        chk("s6_press_after", cnt_press[2] - base_p[2], 1);
        chk("s6_press_delay", int'(last_press_t[2] - rise_t), (int'(DEB) + 3) * 10 + 3);
        key3 = 1'b1; cyc(15);

        // Random independent key activity with bounces, long holds and rare resets.
        lvl = 3'b111;
        for (int c = 0; c < 3; c++) dur[c] = 1;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 3; c++) begin
                dur[c]--;
                if (dur[c] <= 0) begin
                    lvl[c] = ~lvl[c];
                    dur[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4))
                                                         : int'($urandom_range(5, 40));
                end
            end
            {key3, key2, key1} = lvl;
            rstn = ($urandom_range(0, 599) != 0);
            cyc(1);
        end
        rstn = 1'b1;
        {key3, key2, key1} = 3'b111;
        cyc(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
